// File: rtl/mat_mul.sv
// mat_mul: fully pipelined signed N x N matrix multiplier.
// One register stage of products, then a registered binary adder tree per output element.
module mat_mul #(
    parameter int W_IN  = 8,
    parameter int W_OUT = 32,
    parameter int N     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cen,
    input  logic                    valid_in,
    input  logic signed [W_IN-1:0]  matrix_1 [N][N],
    input  logic signed [W_IN-1:0]  matrix_2 [N][N],
    output logic                    valid_out,
    output logic signed [W_OUT-1:0] result [N][N]
);
    localparam int LAT = $clog2(N) + 1;
    localparam int H = N / 2;
    logic signed [W_OUT-1:0] prod_d [N][N][N];
    logic signed [W_OUT-1:0] prod_q [N][N][N];
    logic signed [W_OUT-1:0] sum_d [LAT-1][N][N][H];
    logic signed [W_OUT-1:0] sum_q [LAT-1][N][N][H];
    logic [LAT-1:0] vld;
    for (genvar i = 0; i < N; i++) begin : g_i
        for (genvar j = 0; j < N; j++) begin : g_j
            for (genvar k = 0; k < N; k++) begin : g_k
                logic signed [2*W_IN-1:0] p;
                assign p = matrix_1[i][k] * matrix_2[k][j];
                assign prod_d[i][j][k] = W_OUT'(p);
            end
            assign result[i][j] = sum_q[LAT-2][i][j][0];
        end
    end
    // Level l keeps N>>(l+1) live terms; the remaining slots are tied to zero.
    for (genvar l = 0; l < LAT - 1; l++) begin : g_l
        for (genvar i = 0; i < N; i++) begin : g_i
            for (genvar j = 0; j < N; j++) begin : g_j
                for (genvar k = 0; k < H; k++) begin : g_k
                    if (k < (N >> (l + 1))) begin : g_add
                        if (l == 0) begin : g_first
                            assign sum_d[l][i][j][k] = prod_q[i][j][2*k] + prod_q[i][j][2*k+1];
                        end else begin : g_next
                            assign sum_d[l][i][j][k] = sum_q[l-1][i][j][2*k] + sum_q[l-1][i][j][2*k+1];
                        end
                    end else begin : g_zero
                        assign sum_d[l][i][j][k] = '0;
                    end
                end
            end
        end
    end
    assign valid_out = vld[LAT-1];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '{default: '0};
            sum_q  <= '{default: '0};
            vld    <= '0;
        end else if (cen) begin
            prod_q <= prod_d;
            sum_q  <= sum_d;
            vld    <= {vld[LAT-2:0], valid_in};
        end
    end
endmodule

// File: tb/tb_mat_mul.sv
// tb_mat_mul: directed checks of the 8x8 pipelined matrix multiplier
// (latency 4) covering reset, corner values, streaming, stall and mid-run reset.
module tb_mat_mul;
    logic clk = 0;
    logic rst = 0;
    logic cen = 1;
    logic valid_in = 0;
    logic signed [7:0] m1 [8][8];
    logic signed [7:0] m2 [8][8];
    logic valid_out;
    logic signed [31:0] result [8][8];
    logic signed [7:0] a_bb [10][8][8];
    logic signed [7:0] b_bb [10][8][8];
    logic signed [31:0] e_bb [10][8][8];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mat_mul dut (
        .clk(clk), .rst(rst), .cen(cen), .valid_in(valid_in),
        .matrix_1(m1), .matrix_2(m2), .valid_out(valid_out), .result(result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int av, input int bv);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                m1[r][c] = 8'(av);
                m2[r][c] = 8'(bv);
            end
    endtask

    task automatic test_reset();
        set_all(5, 5);
        valid_in = 1;
        cen = 0;
        #1 rst = 1;
        #2;
        n_chk++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset valid_out: got %b want 0", valid_out); end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                n_chk++;
                if (result[r][c] !== 32'sd0) begin n_fail++; $display("FAIL reset result[%0d][%0d]: got %0d want 0", r, c, result[r][c]); end
            end
        tick();
        tick();
        rst = 0;
        cen = 1;
        valid_in = 0;
        set_all(0, 0);
    endtask

    task automatic test_identity();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                m1[r][c] = (r == c) ? 8'sd1 : 8'sd0;
                m2[r][c] = 8'(r * 8 + c - 64);
            end
        valid_in = 1;
        tick();
        valid_in = 0;
        set_all(0, 0);
        tick();
        tick();
        n_chk++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL identity early valid_out: got %b want 0", valid_out); end
        tick();
        n_chk++;
        if (valid_out !== 1'b1) begin n_fail++; $display("FAIL identity valid_out: got %b want 1", valid_out); end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                n_chk++;
                if (result[r][c] !== 32'(r * 8 + c - 64)) begin n_fail++; $display("FAIL identity result[%0d][%0d]: got %0d want %0d", r, c, result[r][c], r * 8 + c - 64); end
            end
    endtask

    task automatic test_extreme();
        set_all(-128, -128);
        valid_in = 1;
        tick();
        valid_in = 0;
        set_all(0, 0);
        repeat (3) tick();
        n_chk++;
        if (valid_out !== 1'b1) begin n_fail++; $display("FAIL extreme valid_out: got %b want 1", valid_out); end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                n_chk++;
                if (result[r][c] !== 32'sd131072) begin n_fail++; $display("FAIL extreme result[%0d][%0d]: got %0d want 131072", r, c, result[r][c]); end
            end
    endtask

    task automatic test_mixed();
        int av [2] = '{127, 127};
        int bv [2] = '{-128, 127};
        int ev [2] = '{-130048, 129032};
        for (int t = 0; t < 2; t++) begin
            set_all(av[t], bv[t]);
            valid_in = 1;
            tick();
            valid_in = 0;
            set_all(0, 0);
            repeat (3) tick();
            n_chk++;
            if (valid_out !== 1'b1) begin n_fail++; $display("FAIL mixed%0d valid_out: got %b want 1", t, valid_out); end
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    n_chk++;
                    if (result[r][c] !== 32'(ev[t])) begin n_fail++; $display("FAIL mixed%0d result[%0d][%0d]: got %0d want %0d", t, r, c, result[r][c], ev[t]); end
                end
        end
    endtask

    task automatic test_back_to_back();
        void'($urandom(56));
        for (int p = 0; p < 10; p++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    a_bb[p][r][c] = 8'($urandom);
                    b_bb[p][r][c] = 8'($urandom);
                end
        for (int p = 0; p < 10; p++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    int acc = 0;
                    for (int k = 0; k < 8; k++) acc += int'(a_bb[p][r][k]) * int'(b_bb[p][k][c]);
                    e_bb[p][r][c] = 32'(acc);
                end
        for (int s = 0; s < 14; s++) begin
            valid_in = (s < 10);
            if (s < 10) begin
                m1 = a_bb[s];
                m2 = b_bb[s];
            end else set_all(0, 0);
            tick();
            n_chk++;
            if (valid_out !== ((s >= 3 && s <= 12) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL b2b valid_out step %0d: got %b", s, valid_out); end
            if (s >= 3 && s <= 12)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) begin
                        n_chk++;
                        if (result[r][c] !== e_bb[s-3][r][c]) begin n_fail++; $display("FAIL b2b pair%0d result[%0d][%0d]: got %0d want %0d", s - 3, r, c, result[r][c], e_bb[s-3][r][c]); end
                    end
        end
        valid_in = 0;
    endtask

    task automatic test_stall();
        set_all(0, 0);
        valid_in = 0;
        repeat (4) tick();
        set_all(127, -128);
        valid_in = 1;
        tick();
        set_all(0, 0);
        valid_in = 0;
        tick();
        cen = 0;
        set_all(1, 1);
        valid_in = 1;
        for (int s = 0; s < 3; s++) begin
            tick();
            n_chk++;
            if (valid_out !== 1'b0) begin n_fail++; $display("FAIL stall%0d valid_out: got %b want 0", s, valid_out); end
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    n_chk++;
                    if (result[r][c] !== 32'sd0) begin n_fail++; $display("FAIL stall%0d result[%0d][%0d]: got %0d want 0", s, r, c, result[r][c]); end
                end
        end
        cen = 1;
        set_all(0, 0);
        valid_in = 0;
        tick();
        n_chk++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL stall resume valid_out: got %b want 0", valid_out); end
        tick();
        n_chk++;
        if (valid_out !== 1'b1) begin n_fail++; $display("FAIL stall done valid_out: got %b want 1", valid_out); end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                n_chk++;
                if (result[r][c] !== -32'sd130048) begin n_fail++; $display("FAIL stall done result[%0d][%0d]: got %0d want -130048", r, c, result[r][c]); end
            end
        tick();
        n_chk++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL stall dup valid_out: got %b want 0", valid_out); end
    endtask

    task automatic test_reset_mid();
        set_all(127, 127);
        valid_in = 0;
        repeat (4) tick();
        valid_in = 1;
        tick();
        valid_in = 0;
        tick();
        #2 rst = 1;
        #1;
        n_chk++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL midrst valid_out: got %b want 0", valid_out); end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                n_chk++;
                if (result[r][c] !== 32'sd0) begin n_fail++; $display("FAIL midrst result[%0d][%0d]: got %0d want 0", r, c, result[r][c]); end
            end
        set_all(0, 0);
        tick();
        rst = 0;
        for (int s = 0; s < 5; s++) begin
            tick();
            n_chk++;
            if (valid_out !== 1'b0) begin n_fail++; $display("FAIL postrst%0d valid_out: got %b want 0", s, valid_out); end
            n_chk++;
            if (result[3][5] !== 32'sd0) begin n_fail++; $display("FAIL postrst%0d result[3][5]: got %0d want 0", s, result[3][5]); end
        end
        set_all(127, 127);
        valid_in = 1;
        tick();
        valid_in = 0;
        set_all(0, 0);
        repeat (3) tick();
        n_chk++;
        if (valid_out !== 1'b1) begin n_fail++; $display("FAIL recover valid_out: got %b want 1", valid_out); end
        n_chk++;
        if (result[7][0] !== 32'sd129032) begin n_fail++; $display("FAIL recover result[7][0]: got %0d want 129032", result[7][0]); end
    endtask

    initial begin
        set_all(0, 0);
        test_reset();
        test_identity();
        test_extreme();
        test_mixed();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mat_mul.md
MAT_MUL -- requirements
Module: mat_mul

Interface
REQ-001 Parameter W_IN, default 8: signed input element width in bits.
REQ-002 Parameter W_OUT, default 32: signed result element width in bits.
REQ-003 Parameter N, default 8: matrix dimension, N x N; N SHALL be a power of two and at least 2.
REQ-004 Local constant LAT = $clog2(N)+1: pipeline latency in clock cycles.
REQ-005 Port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port cen, input, 1 bit: clock enable; 1 advances the pipeline, 0 freezes it.
REQ-008 Port valid_in, input, 1 bit: matrix_1 and matrix_2 carry a valid operand pair.
REQ-009 Port matrix_1, input, signed [W_IN-1:0] [N][N]: left operand A, indexed [row][col].
REQ-010 Port matrix_2, input, signed [W_IN-1:0] [N][N]: right operand B, indexed [row][col].
REQ-011 Port valid_out, output, 1 bit: result holds the product of the operand pair accepted LAT enabled cycles earlier.
REQ-012 Port result, output, signed [W_OUT-1:0] [N][N]: registered product C = A x B.

Function
REQ-013 Each element SHALL satisfy C[i][j] = sum over k = 0..N-1 of A[i][k]*B[k][j], computed as signed two's complement.
REQ-014 Each product SHALL be a full-precision 2*W_IN-bit signed value, sign-extended to W_OUT.
REQ-015 Accumulation SHALL use W_OUT bits and wrap modulo 2^W_OUT; no saturation is applied and no overflow is flagged.
REQ-016 Stage 1 SHALL register all N^3 products at the first enabled rising edge after the operands are presented.
REQ-017 Stages 2 to LAT SHALL form a registered binary adder tree with $clog2(N) levels; each level halves the term count for every (i,j).
REQ-018 The final adder-tree level SHALL drive result directly from registers, with no combinational path from inputs to result.
REQ-019 Operands presented before rising edge e SHALL appear on result after rising edge e+LAT-1, i.e. LAT edges counting e; with N=8 this is 4 edges.
REQ-020 The pipeline SHALL be fully pipelined: a new operand pair may be accepted every enabled cycle, and results emerge in input order at one per cycle.
REQ-021 valid_in SHALL be delayed through a LAT-deep shift register alongside the data, and its output drives valid_out.
REQ-022 The datapath SHALL compute regardless of valid_in; valid_in only qualifies valid_out.
REQ-023 When cen=0, all pipeline registers, including the valid shift register, SHALL hold their values, and result and valid_out SHALL stay constant.
REQ-024 When cen returns to 1, the pipeline SHALL resume with no data lost or duplicated.

Reset
REQ-025 While rst=1, all pipeline registers, all result elements and valid_out SHALL be 0, independent of clk and cen.
REQ-026 Asserting rst mid-operation SHALL discard all in-flight data.
REQ-027 After rst is released, valid_out SHALL remain 0 until an operand pair accepted with valid_in=1 has traversed LAT enabled cycles.

Verification
REQ-028 Identity case: A = I and B[r][c] = r*8+c-64, with cen=1 and valid_in=1 -> after 4 edges result = B and valid_out=1.
REQ-029 Extreme negative case: all A and all B elements = -128 -> every result element = 131072 and valid_out=1 after 4 edges.
REQ-030 Mixed-sign case: all A elements = 127 and all B elements = -128 -> every result element = -130048; separately, all elements = 127 -> every result element = 129032.
REQ-031 Back-to-back case: 10 random operand pairs (seed 56) on consecutive cycles -> 10 consecutive results, each equal to the 32-bit signed reference product, with valid_out high for exactly those 10 cycles.
REQ-032 Stall case: cen=0 for 3 cycles while a pair is in flight -> result and valid_out frozen during the stall; the correct result appears LAT enabled edges after acceptance.
REQ-033 Reset case: assert rst 2 cycles after accepting a pair -> result is all 0 and valid_out=0 immediately and on every later cycle until a new pair completes.
